// File: rtl/definitions_pkg.sv
// ----------------------------------------------------------------------------
// definitions
//   Shared constants for the RV32I fetch stage and its bench.
//   Contents:
//     CLOCK_PERIOD         bench clock period (time units)
//     XLEN                 architectural register / PC width
//     DEFAULT_RESET_VECTOR PC value loaded on reset (default for RESET_VECTOR)
//     NOP_INSTR            canonical NOP encoding (ADDI x0,x0,0)
//     ROM_WORDS_USED       number of non-zero words at the bottom of the ROM
//     ROM_INIT             instruction ROM image; all other words read as zero
//     rom_word()           ROM lookup helper (returns zero past the image)
// ----------------------------------------------------------------------------
package definitions;

    localparam int unsigned  CLOCK_PERIOD         = 10;
    localparam int unsigned  XLEN                 = 32;
    localparam logic [31:0]  DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0]  NOP_INSTR            = 32'h0000_0013;

    localparam int unsigned  ROM_WORDS_USED = 4;

    localparam logic [31:0]  ROM_INIT [ROM_WORDS_USED] = '{
        32'h0020_0093,   // ADDI x1,x0,2
        32'h0030_0113,   // ADDI x2,x0,3
        32'h0020_81b3,   // ADD  x3,x1,x2
        32'h0000_006f    // JAL  x0,0
    };

    function automatic logic [31:0] rom_word(input int unsigned idx);
        if (idx < ROM_WORDS_USED) begin
            return ROM_INIT[idx];
        end
        return '0;
    endfunction

endpackage

// File: rtl/instr_mem.sv
// ----------------------------------------------------------------------------
// instr_mem
//   Combinational, read-only instruction ROM, word addressed.
//   Parameters:
//     IMEM_WORDS  depth in 32-bit words (power of two)
//   Ports:
//     i_addr  in   $clog2(IMEM_WORDS)  word index
//     o_data  out  32                  instruction word at i_addr
// ----------------------------------------------------------------------------
module instr_mem
    import definitions::*;
#(
    parameter int unsigned IMEM_WORDS = 256,
    localparam int unsigned ADDR_W    = $clog2(IMEM_WORDS)
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       o_data
);

    always_comb begin
        o_data = rom_word(int'(i_addr));
    end

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the RV32I five-stage pipeline. Holds the PC
//   and presents PC, PC+4 and the instruction at PC to the IF/ID register.
//   Parameters:
//     IMEM_WORDS    instruction ROM depth in words (power of two)
//     RESET_VECTOR  PC value loaded on reset
//   Ports:
//     CLK          in   1   pipeline clock, rising edge
//     RST          in   1   asynchronous active-low reset
//     PC_En        in   1   1 = advance PC by 4, 0 = stall
//     PC_Redirect  in   1   (FETCH_REDIRECT_EN only) load PC from PC_Target
//     PC_Target    in   32  (FETCH_REDIRECT_EN only) redirect target
//     Instr        out  32  instruction word at PC_Out
//     PC_Out       out  32  current PC
//     PC_Plus_4    out  32  PC_Out + 4 (wraps modulo 2^32)
//   Build option:
//     FETCH_REDIRECT_EN  adds the redirect ports; redirect beats stall.
// ----------------------------------------------------------------------------
module fetch_stage
    import definitions::*;
#(
    parameter int unsigned IMEM_WORDS   = 256,
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PC_En,
`ifdef FETCH_REDIRECT_EN
    input  logic        PC_Redirect,
    input  logic [31:0] PC_Target,
`endif
    output logic [31:0] Instr,
    output logic [31:0] PC_Out,
    output logic [31:0] PC_Plus_4
);

    localparam int unsigned ADDR_W = $clog2(IMEM_WORDS);

    logic [31:0]       r_pc;
    logic [31:0]       w_pc_plus_4;
    logic [ADDR_W-1:0] w_rom_addr;

    // Unsigned 32-bit add; carry out is dropped so 0xFFFF_FFFC wraps to 0.
    assign w_pc_plus_4 = r_pc + 32'd4;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pc <= RESET_VECTOR;
        end else begin
`ifdef FETCH_REDIRECT_EN
            if (PC_Redirect) begin
                r_pc <= {PC_Target[31:2], 2'b00};
            end else if (PC_En) begin
                r_pc <= w_pc_plus_4;
            end
`else
            if (PC_En) begin
                r_pc <= w_pc_plus_4;
            end
`endif
        end
    end

    // Byte offset and bits above the ROM depth are dropped, so the ROM
    // aliases every 4*IMEM_WORDS bytes.
    assign w_rom_addr = r_pc[ADDR_W+1:2];

    instr_mem #(
        .IMEM_WORDS (IMEM_WORDS)
    ) u_instr_mem (
        .i_addr (w_rom_addr),
        .o_data (Instr)
    );

    assign PC_Out    = r_pc;
    assign PC_Plus_4 = w_pc_plus_4;

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage with hand-computed expected values.
//   Outputs are sampled on the falling clock edge (or 1 time unit after an
//   asynchronous reset assertion). Define FETCH_REDIRECT_EN to include the
//   redirect vectors.
// ----------------------------------------------------------------------------
module tb_fetch_stage;
    import definitions::*;

    logic        CLK;
    logic        RST;
    logic        PC_En;
`ifdef FETCH_REDIRECT_EN
    logic        PC_Redirect;
    logic [31:0] PC_Target;
`endif
    logic [31:0] Instr;
    logic [31:0] PC_Out;
    logic [31:0] PC_Plus_4;

    int unsigned n_vec;
    int unsigned n_err;

    fetch_stage #(
        .IMEM_WORDS   (256),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .PC_En       (PC_En),
`ifdef FETCH_REDIRECT_EN
        .PC_Redirect (PC_Redirect),
        .PC_Target   (PC_Target),
`endif
        .Instr       (Instr),
        .PC_Out      (PC_Out),
        .PC_Plus_4   (PC_Plus_4)
    );

    initial CLK = 1'b0;
    always #(CLOCK_PERIOD / 2) CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Hand-written ROM image for a 256-word ROM: index is pc[9:2].
    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        logic [7:0] idx;
        idx = pc[9:2];
        case (idx)
            8'd0:    return 32'h0020_0093;
            8'd1:    return 32'h0030_0113;
            8'd2:    return 32'h0020_81b3;
            8'd3:    return 32'h0000_006f;
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic check_pc(input string tag, input logic [31:0] pc);
        check_val({tag, "_pc"},  PC_Out,    pc);
        check_val({tag, "_pc4"}, PC_Plus_4, pc + 32'd4);
        check_val({tag, "_ins"}, Instr,     exp_instr(pc));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        RST   = 1'b0;
        PC_En = 1'b1;
`ifdef FETCH_REDIRECT_EN
        PC_Redirect = 1'b0;
        PC_Target   = '0;
`endif

        // Reset held across two rising edges with PC_En high.
        repeat (2) @(negedge CLK);
        check_val("rst_pc",  PC_Out,    32'h0000_0000);
        check_val("rst_pc4", PC_Plus_4, 32'h0000_0004);
        check_val("rst_ins", Instr,     32'h0020_0093);
        RST = 1'b1;

        // Sequential advance.
        @(negedge CLK); check_pc("adv1", 32'd4);
        @(negedge CLK); check_pc("adv2", 32'd8);

        // Stall two cycles at PC=8, then resume.
        PC_En = 1'b0;
        @(negedge CLK); check_pc("stall1", 32'd8);
        @(negedge CLK); check_pc("stall2", 32'd8);
        PC_En = 1'b1;
        @(negedge CLK); check_pc("resume", 32'd12);

        // Asynchronous reset between edges, PC_En still high.
        RST = 1'b0;
        #1;
        check_val("async_pc", PC_Out, 32'h0000_0000);
        check_val("async_ins", Instr, 32'h0020_0093);
        @(negedge CLK); check_pc("rst_hold", 32'd0);

        // Release with PC_En low: PC must not move.
        PC_En = 1'b0;
        RST   = 1'b1;
        @(negedge CLK); check_pc("rel_stall", 32'd0);

        // 256 enabled cycles: covers zero words past index 3 and the alias
        // at PC=1024 back to word 0.
        PC_En = 1'b1;
        for (int unsigned k = 1; k <= 256; k++) begin
            @(negedge CLK);
            check_pc($sformatf("run%0d", k), 32'(4 * k));
        end
        check_val("alias_ins", Instr, 32'h0020_0093);

`ifdef FETCH_REDIRECT_EN
        // Redirect to 8 while enabled.
        PC_Redirect = 1'b1;
        PC_Target   = 32'h0000_0008;
        @(negedge CLK); check_pc("redir8", 32'd8);

        // Redirect beats stall; target low bits are cleared.
        PC_En     = 1'b0;
        PC_Target = 32'h0000_0007;
        @(negedge CLK); check_pc("redir7", 32'd4);
        check_val("redir7_ins", Instr, 32'h0030_0113);

        // Top of address space, then wrap on the next advance.
        PC_Target = 32'hFFFF_FFFE;
        @(negedge CLK); check_pc("redir_top", 32'hFFFF_FFFC);
        check_val("wrap_pc4", PC_Plus_4, 32'h0000_0000);
        PC_Redirect = 1'b0;
        PC_En       = 1'b1;
        @(negedge CLK); check_pc("wrap", 32'h0000_0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #(CLOCK_PERIOD * 5000);
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32I five-stage pipeline.
- Holds the program counter (PC) and a word-addressed instruction ROM.
- Each cycle it presents the current PC, PC+4 and the instruction at PC to the IF/ID pipeline register.
- Stalls when the hazard unit deasserts PC_En.

Parameters:
- IMEM_WORDS, 256, instruction ROM depth in 32-bit words; must be a power of two.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  pipeline clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- PC_En  in  1  PC write enable: 1 = advance, 0 = stall.
- Instr  out  32  instruction word at PC_Out.
- PC_Out  out  32  current PC.
- PC_Plus_4  out  32  PC_Out + 4.

Behaviour:
- Interface (already decided): one clock, CLK; reset RST is asynchronous and active-low.
- Reset:
  - RST low forces the PC register to RESET_VECTOR immediately, without waiting for a clock edge.
  - While RST is low: PC_Out = 0, PC_Plus_4 = 4, Instr = ROM[0] (32'h00200093).
  - First advance happens at the first rising CLK edge with RST high and PC_En high.
- PC update at each rising edge with RST high:
  - PC_En = 1: PC <= PC + 4.
  - PC_En = 0: PC holds its value.
- Arithmetic:
  - PC + 4 is unsigned 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
  - PC_Plus_4 is combinational from PC_Out.
- Instruction ROM:
  - Combinational, zero-latency read; Instr changes in the same cycle PC_Out changes.
  - Index = PC[log2(IMEM_WORDS)+1:2]. PC[1:0] is ignored; upper PC bits are ignored, so addresses alias modulo 4*IMEM_WORDS bytes.
  - Required contents:
    - word 0 = 32'h00200093 (ADDI x1,x0,2)
    - word 1 = 32'h00300113 (ADDI x2,x0,3)
    - word 2 = 32'h002081b3 (ADD x3,x1,x2)
    - word 3 = 32'h0000006f (JAL x0,0)
    - every other word = 32'h00000000
  - The ROM is read-only; there is no write port.
- Reset mid-operation: the asynchronous clear overrides any PC_En value. On release, PC stays at RESET_VECTOR until the next qualifying edge.
- No redirect or branch input in the base configuration; PC is strictly sequential.

Optional Feature:
- Macro: FETCH_REDIRECT_EN.
- When defined, two input ports are added:
  - PC_Redirect, 1 bit.
  - PC_Target, 32 bits.
- Priority at a rising edge with RST high: PC_Redirect = 1 loads PC <= {PC_Target[31:2], 2'b00}, regardless of PC_En (redirect beats stall). Otherwise the base rules apply.
- Reset still dominates.
- When undefined, the ports do not exist and the behaviour is exactly as specified above.

Decomposition:
- Shared package `definitions` holds:
  - CLOCK_PERIOD (bench use);
  - RESET_VECTOR default;
  - XLEN = 32;
  - NOP encoding 32'h00000013;
  - ROM contents as a constant array, or an init-file name constant.
- One natural sub-module: `instr_mem`, the combinational ROM with address-in / data-out. The PC register and adder stay in fetch_stage.

Test Plan:
- Hold RST low 2 cycles, then release with PC_En=1 → PC_Out=0, Instr=32'h00200093 during reset. After release PC_Out steps 4, 8, 12; Instr steps 32'h00300113, 32'h002081b3, 32'h0000006f; PC_Plus_4 always = PC_Out+4.
- Run to PC_Out=16 and beyond → Instr=32'h00000000 for every word index ≥4.
- PC_En=0 for 2 cycles at PC_Out=8 → PC_Out stays 8 and Instr stays 32'h002081b3. Re-enable → next edge gives 12.
- Assert RST low between clock edges while PC_Out=12 → PC_Out drops to 0 before the next edge. It holds 0 while low, and holds 0 at PC_En=0 after release.
- Run 256 enabled cycles from reset → PC_Out=1024 aliases to word 0, so Instr=32'h00200093.
- With FETCH_REDIRECT_EN: PC_Out=8, PC_En=0, PC_Redirect=1, PC_Target=32'h7 → next PC_Out=4, Instr=32'h00300113.
